// File: rtl/gate_preact_mac.sv
// Gate pre-activation MAC: streams x/w beats into a wide accumulator, adds the gate bias,
// rounds half-up to S7.8 and saturates, then holds the result for the sigmoid/tanh stage.
module gate_preact_mac #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int LEN_WIDTH = 8,
  parameter int ACC_WIDTH = 40
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic        [LEN_WIDTH-1:0] vec_len,
  input  logic signed [WIDTH-1:0]     bias_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     x_in,
  input  logic signed [WIDTH-1:0]     w_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic        [WIDTH-1:0]     preact_out,
  output logic                        overflow,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} state_t;

  localparam logic signed [ACC_WIDTH-1:0] R_MAX = (ACC_WIDTH'(1) << (WIDTH-1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] R_MIN = -(ACC_WIDTH'(1) << (WIDTH-1));
  localparam logic signed [ACC_WIDTH-1:0] RND   = ACC_WIDTH'(1) << (FRAC_BITS-1);

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic        [LEN_WIDTH-1:0]   cnt_q, len_q, cnt_nxt;
  logic signed [WIDTH-1:0]       bias_q;
  logic        [WIDTH-1:0]       res_q, res_d;
  logic                          ovf_q, ovf_d;
  logic                          beat;
  logic signed [2*WIDTH-1:0]     prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext, bias_ext, sum, r;

  assign in_ready   = (state_q == ACC);
  assign out_valid  = (state_q == OUT);
  assign busy       = (state_q != IDLE);
  assign preact_out = res_q;
  assign overflow   = ovf_q;

  assign beat     = in_valid & in_ready;
  assign cnt_nxt  = cnt_q + LEN_WIDTH'(1);
  assign prod     = x_in * w_in;
  assign prod_ext = {{(ACC_WIDTH-2*WIDTH){prod[2*WIDTH-1]}}, prod};

  // Bias is aligned to the product's 2*FRAC_BITS scale before rounding back to FRAC_BITS.
  assign bias_ext = {{(ACC_WIDTH-WIDTH){bias_q[WIDTH-1]}}, bias_q} <<< FRAC_BITS;
  assign sum      = acc_q + bias_ext + RND;
  assign r        = sum >>> FRAC_BITS;

  always_comb begin
    res_d = r[WIDTH-1:0];
    ovf_d = 1'b0;
    if (r > R_MAX) begin
      res_d = {1'b0, {(WIDTH-1){1'b1}}};
      ovf_d = 1'b1;
    end else if (r < R_MIN) begin
      res_d = {1'b1, {(WIDTH-1){1'b0}}};
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (vec_len == '0) ? ROUND : ACC;
      ACC:     if (beat && cnt_nxt == len_q) state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      bias_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          len_q  <= vec_len;
          bias_q <= bias_in;
          acc_q  <= '0;
          cnt_q  <= '0;
        end
        ACC: if (beat) begin
          acc_q <= acc_q + prod_ext;
          cnt_q <= cnt_nxt;
        end
        ROUND: begin
          res_q <= res_d;
          ovf_q <= ovf_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_preact_mac.sv
// Directed bench for gate_preact_mac: expected results are queued when a vector is started
// and compared when the block presents out_valid.
module tb_gate_preact_mac;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  vec_len = '0;
  logic [15:0] bias_in = '0, x_in = '0, w_in = '0;
  logic        in_ready, out_valid, overflow, busy;
  logic [15:0] preact_out;

  int          n_vec = 0, n_err = 0;
  logic [16:0] sb[$];
  logic [15:0] xa[8], wa[8];
  logic [16:0] held;

  always #5 clk = ~clk;

  gate_preact_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .bias_in(bias_in),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .preact_out(preact_out),
    .overflow(overflow), .busy(busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer math, round half-up, saturate to S7.8.
  function automatic logic [16:0] model(input int len, input logic [15:0] b);
    longint s = 0;
    for (int i = 0; i < len; i++)
      s += longint'(signed'(xa[i])) * longint'(signed'(wa[i]));
    s += longint'(signed'(b)) * 256 + 128;
    s = s >>> 8;
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  task automatic feed(input int len, input logic [15:0] b, input bit gap);
    sb.push_back(model(len, b));
    start = 1'b1; vec_len = len[7:0]; bias_in = b;
    step;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 1);
    for (int i = 0; i < len; i++) begin
      check("in_ready_acc", {31'd0, in_ready}, 1);
      in_valid = 1'b1; x_in = xa[i]; w_in = wa[i];
      step;
      in_valid = 1'b0;
      if (gap && i != len - 1) begin
        x_in = 16'h7FFF; w_in = 16'h7FFF;
        step;
      end
    end
    check("in_ready_after_last", {31'd0, in_ready}, 0);
    check("out_valid_early", {31'd0, out_valid}, 0);
    step;
    check("out_valid_latency", {31'd0, out_valid}, 1);
  endtask

  task automatic drain;
    logic [16:0] e;
    check("sb_nonempty", {31'd0, sb.size() != 0}, 1);
    e = (sb.size() != 0) ? sb.pop_front() : 17'h0;
    check("preact_out", {16'd0, preact_out}, {16'd0, e[15:0]});
    check("overflow", {31'd0, overflow}, {31'd0, e[16]});
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check("out_valid_clear", {31'd0, out_valid}, 0);
    check("busy_clear", {31'd0, busy}, 0);
  endtask

  initial begin
    #12;
    check("rst_preact", {16'd0, preact_out}, 0);
    check("rst_flags", {28'd0, in_ready, out_valid, overflow, busy}, 0);
    @(negedge clk); rst_n = 1'b1;
    step;

    // 1.0 * 2.0
    xa[0] = 16'h0100; wa[0] = 16'h0200;
    feed(1, 16'h0000, 1'b0); drain;

    // 1.0 - 1.0 + 0.5 + bias 0.5 with gapped beats
    xa[0] = 16'h0100; xa[1] = 16'hFF00; xa[2] = 16'h0080;
    wa[0] = 16'h0100; wa[1] = 16'h0100; wa[2] = 16'h0100;
    feed(3, 16'h0080, 1'b1);
    check("gapped_value", {16'd0, sb[0][15:0]}, 32'h0100);
    drain;

    // positive and negative saturation
    xa[0] = 16'h7FFF; xa[1] = 16'h7FFF; wa[0] = 16'h7FFF; wa[1] = 16'h7FFF;
    feed(2, 16'h0000, 1'b0); drain;
    wa[0] = 16'h8000; wa[1] = 16'h8000;
    feed(2, 16'h0000, 1'b0); drain;

    // zero-length vector: bias alone
    feed(0, 16'hFA00, 1'b0); drain;

    // back-pressure: result held, start/in_valid ignored
    xa[0] = 16'h0300; wa[0] = 16'h0100;
    feed(1, 16'h0040, 1'b0);
    held = sb[0];
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; vec_len = 8'(i + 1); bias_in = 16'hFFFF;
      in_valid = 1'b1; x_in = 16'h1234; w_in = 16'h4321;
      step;
      check("hold_valid", {31'd0, out_valid}, 1);
      check("hold_preact", {16'd0, preact_out}, {16'd0, held[15:0]});
      check("hold_overflow", {31'd0, overflow}, {31'd0, held[16]});
    end
    start = 1'b0; in_valid = 1'b0;
    drain;

    // in_valid while idle counts nothing
    in_valid = 1'b1; x_in = 16'h0100; w_in = 16'h0100;
    step; step;
    check("idle_in_ready", {31'd0, in_ready}, 0);
    in_valid = 1'b0;
    xa[0] = 16'hFE80; wa[0] = 16'h0200;
    feed(1, 16'h0000, 1'b0); drain;

    // async reset mid-ACC after 2 of 4 beats
    for (int i = 0; i < 4; i++) begin xa[i] = 16'h0400; wa[i] = 16'h0400; end
    start = 1'b1; vec_len = 8'd4; bias_in = 16'h0100;
    step;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x_in = xa[i]; w_in = wa[i];
      step;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_preact", {16'd0, preact_out}, 0);
    check("async_rst_flags", {28'd0, in_ready, out_valid, overflow, busy}, 0);
    @(negedge clk); rst_n = 1'b1;
    step;
    xa[0] = 16'h0100; wa[0] = 16'h0100;
    feed(1, 16'h0000, 1'b0);
    check("post_rst_value", {16'd0, sb[0][15:0]}, 32'h0100);
    drain;

    // pseudo-random vector
    for (int i = 0; i < 6; i++) begin
      xa[i] = 16'($urandom_range(0, 16'hFFFF));
      wa[i] = 16'($urandom_range(0, 16'hFFFF)) >>> 4;
    end
    feed(6, 16'($urandom_range(0, 16'hFFFF)), 1'b1); drain;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
